// File: rtl/ex_stage.sv
// Execute stage of the pipelined LEGv8 core.
// Holds the ID/EX register, resolves operand forwarding from EX/MEM and MEM/WB,
// evaluates the ALU and branch target, and registers everything into EX/MEM.
module ex_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         id_valid,
    input  logic [N-1:0] id_pc,
    input  logic [N-1:0] id_rd1,
    input  logic [N-1:0] id_rd2,
    input  logic [N-1:0] id_imm,
    input  logic [4:0]   id_rs1,
    input  logic [4:0]   id_rs2,
    input  logic [4:0]   id_rd,
    input  logic         id_alusrc,
    input  logic [3:0]   id_alucontrol,
    input  logic         id_regwrite,
    input  logic         id_memwrite,
    input  logic         id_memtoreg,
    input  logic         id_branch,
    input  logic         wb_regwrite,
    input  logic [4:0]   wb_rd,
    input  logic [N-1:0] wb_data,
    output logic         ex_valid,
    output logic [N-1:0] ex_result,
    output logic         ex_zero,
    output logic [N-1:0] ex_writedata,
    output logic [N-1:0] ex_branch_target,
    output logic [4:0]   ex_rd,
    output logic         ex_regwrite,
    output logic         ex_memwrite,
    output logic         ex_memtoreg,
    output logic         ex_branch
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [4:0] XZR      = 5'd31;

    // ID/EX pipeline register
    logic                vld_p0;
    logic [N-1:0]        pc_p0;
    logic [N-1:0]        rd1_p0;
    logic [N-1:0]        rd2_p0;
    logic signed [N-1:0] imm_p0;
    logic [4:0]          rs1_p0;
    logic [4:0]          rs2_p0;
    logic [4:0]          rd_p0;
    logic                alusrc_p0;
    logic [3:0]          aluc_p0;
    logic                regwrite_p0;
    logic                memwrite_p0;
    logic                memtoreg_p0;
    logic                branch_p0;

    logic [N-1:0] opa;
    logic [N-1:0] fwd_b;
    logic [N-1:0] opb;
    logic [N-1:0] alu_res;
    logic [N-1:0] target;

    // Undefined opcodes return all ones so they are easy to spot downstream.
    function automatic logic [N-1:0] alu_eval(input logic [N-1:0] a,
                                              input logic [N-1:0] b,
                                              input logic [3:0]   ctl);
        logic [N-1:0] r;
        case (ctl)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_PASS: r = b;
            default:  r = '1;
        endcase
        return r;
    endfunction

    // A load in EX/MEM has no data yet, so it is skipped; the hazard unit
    // is responsible for stalling the consumer in that case.
    function automatic logic [N-1:0] fwd_sel(input logic [4:0]   rs,
                                             input logic [N-1:0] regval);
        logic [N-1:0] v;
        v = regval;
        if (rs != XZR) begin
            if (ex_valid && ex_regwrite && !ex_memtoreg && ex_rd == rs)
                v = ex_result;
            else if (wb_regwrite && wb_rd == rs)
                v = wb_data;
        end
        return v;
    endfunction

    // Capture decode outputs; reset beats flush, flush beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            pc_p0       <= '0;
            rd1_p0      <= '0;
            rd2_p0      <= '0;
            imm_p0      <= '0;
            rs1_p0      <= '0;
            rs2_p0      <= '0;
            rd_p0       <= '0;
            alusrc_p0   <= 1'b0;
            aluc_p0     <= '0;
            regwrite_p0 <= 1'b0;
            memwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            branch_p0   <= 1'b0;
        end else if (flush) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            memwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            branch_p0   <= 1'b0;
        end else if (!stall) begin
            vld_p0      <= id_valid;
            pc_p0       <= id_pc;
            rd1_p0      <= id_rd1;
            rd2_p0      <= id_rd2;
            imm_p0      <= id_imm;
            rs1_p0      <= id_rs1;
            rs2_p0      <= id_rs2;
            rd_p0       <= id_rd;
            alusrc_p0   <= id_alusrc;
            aluc_p0     <= id_alucontrol;
            regwrite_p0 <= id_regwrite & id_valid;
            memwrite_p0 <= id_memwrite & id_valid;
            memtoreg_p0 <= id_memtoreg & id_valid;
            branch_p0   <= id_branch & id_valid;
        end
    end

    // Operand selection, ALU and branch target for the instruction in ID/EX.
    always_comb begin
        opa     = fwd_sel(rs1_p0, rd1_p0);
        fwd_b   = fwd_sel(rs2_p0, rd2_p0);
        opb     = alusrc_p0 ? imm_p0 : fwd_b;
        alu_res = alu_eval(opa, opb, aluc_p0);
        target  = pc_p0 + (imm_p0 <<< 2);
    end

    // EX/MEM pipeline register; controls of a bubble are forced low.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid         <= 1'b0;
            ex_result        <= '0;
            ex_zero          <= 1'b0;
            ex_writedata     <= '0;
            ex_branch_target <= '0;
            ex_rd            <= '0;
            ex_regwrite      <= 1'b0;
            ex_memwrite      <= 1'b0;
            ex_memtoreg      <= 1'b0;
            ex_branch        <= 1'b0;
        end else if (!stall) begin
            ex_valid         <= vld_p0;
            ex_result        <= alu_res;
            ex_zero          <= (alu_res == '0);
            ex_writedata     <= fwd_b;
            ex_branch_target <= target;
            ex_rd            <= rd_p0;
            ex_regwrite      <= regwrite_p0 & vld_p0;
            ex_memwrite      <= memwrite_p0 & vld_p0;
            ex_memtoreg      <= memtoreg_p0 & vld_p0;
            ex_branch        <= branch_p0 & vld_p0;
        end
    end

endmodule
